// File: rtl/hamming_pkg.sv
// Hamming(7,4) types, syndrome patterns and decode helpers for the shared decoder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package hamming_pkg;

  typedef logic [0:6] code_t;
  typedef logic [0:3] data_t;
  typedef logic [0:2] syn_t;

  localparam syn_t SYN_D0 = 3'b110;
  localparam syn_t SYN_D1 = 3'b101;
  localparam syn_t SYN_D2 = 3'b011;
  localparam syn_t SYN_D3 = 3'b111;

  typedef enum logic [1:0] {IDLE, SYND, HOLD} sched_state_t;

  function automatic syn_t calc_syn(input code_t c);
    calc_syn = {c[0] ^ c[1] ^ c[3] ^ c[4],
                c[0] ^ c[2] ^ c[3] ^ c[5],
                c[1] ^ c[2] ^ c[3] ^ c[6]};
  endfunction

  // Single-bit correction only; parity-bit syndromes leave the data untouched.
  function automatic data_t correct(input code_t c, input syn_t s);
    data_t d;
    d = c[0:3];
    case (s)
      SYN_D0:  d[0] = ~d[0];
      SYN_D1:  d[1] = ~d[1];
      SYN_D2:  d[2] = ~d[2];
      SYN_D3:  d[3] = ~d[3];
      default: d = c[0:3];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last accepted requester.
// Latency: combinational grant; last_grant registers on each enabled request.
// Backpressure: en low forces grant to zero and freezes the priority pointer.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] last_grant;
  logic          found;
  int            k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last_grant) + i) % N;
      if (en && !found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IW'(k);
      end
    end
  end

  // Pointer starts at N-1 so requester 0 has first priority after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IW'(N - 1);
    end else if (en && |req) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/hamming_decode_sched.sv
// Shared Hamming(7,4) decoder fed round-robin from N_REQ requesters, with saturating error count.
// Latency: 2 cycles from input handshake to out_valid; one word in flight, 1 word per 3 cycles peak.
// Backpressure: out_ready low holds the word in HOLD with stable outputs and req_ready forced to 0.
module hamming_decode_sched
  import hamming_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  code_t [N_REQ-1:0]          req_code,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output data_t                      out_data,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output syn_t                       out_syn,
  output logic                       out_err,
  input  logic                       clr_count,
  output logic [CNT_W-1:0]           err_count
);

  localparam int ID_W = $clog2(N_REQ);

  sched_state_t    state_q, state_d;
  code_t           code_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] grant_idx;
  logic            in_fire;
  logic            out_fire;
  syn_t            syn_w;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (state_q == IDLE),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign in_fire   = |(req_valid & req_ready);
  assign out_valid = (state_q == HOLD);
  assign out_fire  = out_valid & out_ready;
  assign syn_w     = calc_syn(code_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = SYND;
      SYND:    state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q   <= '0;
      id_q     <= '0;
      out_data <= '0;
      out_id   <= '0;
      out_syn  <= '0;
      out_err  <= 1'b0;
    end else begin
      if (in_fire) begin
        code_q <= req_code[grant_idx];
        id_q   <= grant_idx;
      end
      if (state_q == SYND) begin
        out_data <= correct(code_q, syn_w);
        out_syn  <= syn_w;
        out_err  <= |syn_w;
        out_id   <= id_q;
      end
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (out_fire && out_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_decode_sched.sv
// Scoreboard bench for hamming_decode_sched with three requesters and a 2-bit error counter.
// Stimulus pushes expected words; an independent monitor pops and compares on each output handshake.
module tb_hamming_decode_sched;
  import hamming_pkg::*;

  localparam int N  = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req_valid = '0;
  code_t [N-1:0] req_code = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  data_t         out_data;
  logic [1:0]    out_id;
  syn_t          out_syn;
  logic          out_err;
  logic          clr_count = 1'b0;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  hamming_decode_sched #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_syn   (out_syn),
    .out_err   (out_err),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  typedef struct {
    logic [3:0] data;
    int         id;
    logic [2:0] syn;
    logic       err;
  } exp_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   ts_q[$];
  exp_t e;
  bit   spacing_on = 1'b0;
  int   last_out_cyc = -1;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic push(input logic [3:0] d, input int id, input logic [2:0] s, input logic er);
    exp_t x;
    x.data = d; x.id = id; x.syn = s; x.err = er;
    exp_q.push_back(x);
  endtask

  // Input handshake observer: the transfer completes at the following rising edge.
  always @(negedge clk) begin
    if (reset && |(req_valid & req_ready)) ts_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (reset && out_valid && !prev_valid) begin
      if (ts_q.size() == 0) fail_now("latency_no_handshake");
      else chk("latency", cyc - ts_q.pop_front(), 2);
    end
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_id",   out_id,   e.id);
        chk("out_syn",  out_syn,  e.syn);
        chk("out_err",  out_err,  e.err);
      end
      if (spacing_on && last_out_cyc >= 0) chk("spacing", cyc - last_out_cyc, 3);
      last_out_cyc = cyc;
    end
    prev_valid = out_valid;
  end

  // Hold valid on each requester in mask until it has transferred 'each' words.
  task automatic issue(input logic [N-1:0] mask, input int each);
    int           rem[N];
    int           budget;
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) rem[i] = mask[i] ? each : 0;
    @(posedge clk); #1;
    req_valid = mask;
    budget = 0;
    while (req_valid != '0 && budget < 200) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          rem[i]--;
          if (rem[i] == 0) req_valid[i] = 1'b0;
        end
      end
      budget++;
    end
    if (req_valid != '0) begin
      fail_now("issue_timeout");
      req_valid = '0;
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || out_valid) && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) fail_now("idle_timeout");
    @(negedge clk);
  endtask

  task automatic wait_out_valid();
    int b;
    b = 0;
    while (!out_valid && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (!out_valid) fail_now("out_valid_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_id"},    out_id,    0);
    chk({tag, "_out_syn"},   out_syn,   0);
    chk({tag, "_out_err"},   out_err,   0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;

    // Clean word from requester 0.
    req_code[0] = 7'b1011010;
    push(4'b1011, 0, 3'b000, 1'b0);
    issue(3'b001, 1);
    wait_idle();
    chk("cnt_clean", err_count, 0);

    // Data bit c2 flipped, requester 1.
    req_code[1] = 7'b1001010;
    push(4'b1011, 1, 3'b011, 1'b1);
    issue(3'b010, 1);
    wait_idle();
    chk("cnt_data_err", err_count, 1);

    // Parity bit c5 flipped, requester 2.
    req_code[2] = 7'b1011000;
    push(4'b1011, 2, 3'b010, 1'b1);
    issue(3'b100, 1);
    wait_idle();
    chk("cnt_parity_err", err_count, 2);

    // Fairness: all requesters valid continuously.
    req_code[0] = 7'b1011010;
    req_code[1] = 7'b0000000;
    req_code[2] = 7'b1111111;
    for (int r = 0; r < 2; r++) begin
      push(4'b1011, 0, 3'b000, 1'b0);
      push(4'b0000, 1, 3'b000, 1'b0);
      push(4'b1111, 2, 3'b000, 1'b0);
    end
    spacing_on = 1'b1;
    last_out_cyc = -1;
    issue(3'b111, 2);
    wait_idle();
    spacing_on = 1'b0;
    chk("cnt_fair", err_count, 2);

    // Backpressure: d3 error held 5 cycles while requester 1 waits.
    out_ready = 1'b0;
    req_code[0] = 7'b1100100;
    req_code[1] = 7'b0000000;
    push(4'b1101, 0, 3'b111, 1'b1);
    push(4'b0000, 1, 3'b000, 1'b0);
    fork
      issue(3'b011, 1);
      begin
        wait_out_valid();
        repeat (5) begin
          @(negedge clk);
          chk("bp_valid",    out_valid, 1);
          chk("bp_data",     out_data,  4'b1101);
          chk("bp_id",       out_id,    0);
          chk("bp_syn",      out_syn,   3'b111);
          chk("bp_err",      out_err,   1);
          chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("cnt_bp", err_count, 3);

    // Fourth erroneous word: counter saturates.
    req_code[2] = 7'b1001010;
    push(4'b1011, 2, 3'b011, 1'b1);
    issue(3'b100, 1);
    wait_idle();
    chk("cnt_sat", err_count, 3);

    // Reset while the word is in SYND: it must never be delivered.
    req_code[1] = 7'b1001010;
    issue(3'b010, 1);
    reset = 1'b0;
    ts_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_valid", out_valid, 0);
    end
    chk_reset_outputs("abort");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_after_valid", out_valid, 0);

    // Requester 0 first after reset; clear coincident with an erroneous handshake.
    out_ready = 1'b1;
    req_code[0] = 7'b1011000;
    req_code[1] = 7'b1001010;
    push(4'b1011, 0, 3'b010, 1'b1);
    push(4'b1011, 1, 3'b011, 1'b1);
    fork
      issue(3'b011, 1);
      begin
        while (exp_q.size() > 1) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("cnt_before_clr", err_count, 1);
        wait_out_valid();
        @(posedge clk); #1;
        clr_count = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        @(negedge clk);
        chk("cnt_clr_wins", err_count, 0);
      end
    join
    wait_idle();
    chk("cnt_after_clr", err_count, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/hamming_decode_sched.md
# hamming_decode_sched

Shared-decoder scheduler for the Hamming(7,4) receive path. It accepts 7-bit codewords from `N_REQ` independent requesters and grants them round-robin into a single registered syndrome/correction stage. It returns the corrected 4-bit data with requester ID and syndrome over a valid/ready output port, and keeps a saturating error counter. It sits between the per-channel receive framers and the data sink, replacing one decoder per channel.

## Interface
- `N_REQ`, 2: number of requesters, legal range 2..8.
- `CNT_W`, 16: error counter width.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i presents a codeword.
- `req_code`  in  N_REQ×[0:6]  codeword per requester; bit 0 is the first (MSB) bit; c0..c3 are data d0..d3, c4..c6 are parity.
- `req_ready`  out  N_REQ  one-hot grant; the transfer completes when `req_valid[i]` and `req_ready[i]` are both high.
- `out_valid`  out  1  decoded word available.
- `out_ready`  in  1  sink accepts the word.
- `out_data`  out  [0:3]  corrected data d0..d3.
- `out_id`  out  $clog2(N_REQ)  index of the source requester.
- `out_syn`  out  [0:2]  syndrome s0..s2.
- `out_err`  out  1  syndrome is nonzero.
- `clr_count`  in  1  synchronous clear of `err_count`.
- `err_count`  out  CNT_W  number of delivered words with `out_err`=1, saturating.

## Operation
- The FSM has three states.
  - IDLE: `req_ready` = round-robin grant over `req_valid`. On a handshake, capture the code and ID, then go to SYND. With no valid requester, stay in IDLE and hold `req_ready` at 0.
  - SYND: register the syndrome and the corrected data, then go to HOLD.
  - HOLD: `out_valid`=1. When `out_ready`=1, go to IDLE and update `err_count`. Outputs stay stable while `out_ready`=0.
- `req_ready` is 0 in SYND and HOLD. Only one requester is in flight at a time.
- Syndrome:
  - s0 = c0^c1^c3^c4
  - s1 = c0^c2^c3^c5
  - s2 = c1^c2^c3^c6
- Correction by {s0,s1,s2}:
  - 110 flips d0.
  - 101 flips d1.
  - 011 flips d2.
  - 111 flips d3.
  - 100, 010, 001 indicate a parity-bit error; data passes unchanged.
  - 000 means no error.
  - Double errors are miscorrected by design; no detection.
- Arbitration:
  - Priority starts at `last_grant+1` mod N_REQ.
  - `last_grant` updates on each accepted handshake only.
  - After reset, `last_grant` = N_REQ-1, so requester 0 has first priority.
- The grant is computed combinationally from `req_valid` in IDLE. A requester that drops valid before the handshake loses its turn without penalty.
- Error counter:
  - Increments by 1 on each output handshake with `out_err`=1.
  - Saturates at 2^CNT_W-1.
  - `clr_count` wins over a simultaneous increment, giving 0.

## Timing
- Handshake at edge T → SYND after T → `out_valid`=1 after edge T+1. Latency is 2 cycles.
- Output handshake at edge H → IDLE after H → next grant is possible at edge H+1. Peak throughput is 1 word per 3 cycles.
- Reset values:
  - FSM in IDLE.
  - `req_ready`=0, `out_valid`=0, `out_data`=0, `out_id`=0, `out_syn`=0, `out_err`=0.
  - `err_count`=0, `last_grant`=N_REQ-1.
- Reset asserted mid-operation aborts the in-flight word; no output handshake occurs for it.
- `out_*` data signals are registered; `req_ready` is combinational from state and `req_valid`.

## Structure
- Package `hamming_pkg`:
  - `code_t` (logic [0:6]) and `data_t` (logic [0:3]).
  - Syndrome-pattern constants `SYN_D0`=3'b110, `SYN_D1`=3'b101, `SYN_D2`=3'b011, `SYN_D3`=3'b111.
  - FSM enum `sched_state_t` {IDLE, SYND, HOLD}.
- Sub-module `rr_arbiter` (parameter N), with ports `req`, `en`, `grant` (one-hot), `grant_idx`, and an internal `last_grant` updated when `en & |req`.
- Syndrome and correction logic stays inline as functions in `hamming_pkg`.

## Test plan
- Clean word: req0 sends 1011010 → `out_data`=1011, `out_syn`=000, `out_err`=0, `out_id`=0, `out_valid` two cycles after the handshake; `err_count` stays 0.
- Data-bit error: req1 sends 1001010 (c2 flipped) → `out_data`=1011, `out_syn`=011, `out_err`=1; after the output handshake, `err_count`=1.
- Parity-bit error: 1011000 (c5 flipped) → `out_data`=1011, `out_syn`=010, `out_err`=1.
- Fairness: N_REQ=3 with all valid continuously and `out_ready`=1 → grant order 0,1,2,0,1,2; words spaced 3 cycles apart.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_valid` and `out_*` stable, `req_ready`=0 throughout, no new grant until the release.
- Counter edges: with CNT_W=2, 4 erroneous words → saturates at 3. `clr_count` coincident with an erroneous handshake → 0. Asserting `reset` in SYND → `out_valid` never rises and all outputs return to their reset values.
